// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader_pkg : shared processor constants (opcodes, loader states/base)  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package imem_loader_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] IMEM_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader : streams a program image into instruction memory, then        |
// | releases the CPU from reset. Revision 1.0                                  |
// +----------------------------------------------------------------------------+
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = IMEM_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

  loader_state_e         state_q, state_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  logic                  accept;
  logic [31:0]           word_offset;

  assign accept      = (state_q == ST_LOAD) && in_valid;
  // Count is below DEPTH whenever a word is accepted, so its low bits are the index.
  assign word_offset = 32'(count_q[ADDR_WIDTH-1:0]) << 2;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;

    if (accept) begin
      we_d    = 1'b1;
      addr_d  = BASE_ADDR + word_offset;
      wdata_d = in_data;
      if (count_q != DEPTH) begin
        count_d = count_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (start) begin
          state_d = ST_LOAD;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (in_last) begin
            state_d = ST_DRAIN;
          end else if (count_q == LAST_IDX) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_DRAIN: state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Reset drops any write staged by a same-cycle acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign cpu_reset  = (state_q != ST_RUN);
  assign done       = (state_q == ST_RUN);
  assign error      = (state_q == ST_ERROR);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imem_loader : two loader instances (depth 256 and depth 4) driven by    |
// | shared stimulus and checked against a behavioural model. Revision 1.0      |
// +----------------------------------------------------------------------------+
module tb_imem_loader;

  localparam logic [31:0] S_BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;

  logic        b_ready, b_we, b_cpu_reset, b_done, b_error;
  logic [31:0] b_addr, b_wdata;
  logic [8:0]  b_wc;
  logic        s_ready, s_we, s_cpu_reset, s_done, s_error;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_wc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_loader u_big (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(b_ready), .in_data(in_data), .in_last(in_last),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .cpu_reset(b_cpu_reset), .done(b_done), .error(b_error), .word_count(b_wc)
  );

  imem_loader #(.ADDR_WIDTH(2), .BASE_ADDR(S_BASE)) u_small (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(s_ready), .in_data(in_data), .in_last(in_last),
    .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .cpu_reset(s_cpu_reset), .done(s_done), .error(s_error), .word_count(s_wc)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: loader mode flags, accepted-word count and the write
  // produced by the previous cycle's acceptance, for each instance.
  bit          m_live = 1'b0;
  bit          m_act[2], m_run[2], m_ovf[2], m_fin[2], m_acc[2];
  int          m_cnt[2];
  bit          m_we[2];
  logic [31:0] m_addr[2], m_data[2];
  int          m_depth[2] = '{256, 4};
  logic [31:0] m_base[2]  = '{32'h0, S_BASE};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_act[k] = 0; m_run[k] = 0; m_ovf[k] = 0; m_fin[k] = 0;
        m_cnt[k] = 0; m_we[k] = 0; m_addr[k] = m_base[k]; m_data[k] = 0;
      end else begin
        m_acc[k] = m_act[k] && in_valid;
        m_we[k]  = m_acc[k];
        if (m_acc[k]) begin
          m_addr[k] = m_base[k] + 32'(4 * m_cnt[k]);
          m_data[k] = in_data;
        end
        if (m_fin[k]) begin
          m_fin[k] = 0;
          m_run[k] = 1;
        end else if (m_act[k]) begin
          if (m_acc[k]) begin
            m_cnt[k]++;
            if (in_last) begin
              m_act[k] = 0; m_fin[k] = 1;
            end else if (m_cnt[k] == m_depth[k]) begin
              m_act[k] = 0; m_ovf[k] = 1;
            end
          end
        end else if (start) begin
          m_act[k] = 1; m_run[k] = 0; m_ovf[k] = 0; m_cnt[k] = 0;
        end
      end
    end
    if (reset) m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      cmp("big.in_ready",   32'(b_ready),     32'(m_act[0]));
      cmp("big.cpu_reset",  32'(b_cpu_reset), 32'(!m_run[0]));
      cmp("big.done",       32'(b_done),      32'(m_run[0]));
      cmp("big.error",      32'(b_error),     32'(m_ovf[0]));
      cmp("big.mem_we",     32'(b_we),        32'(m_we[0]));
      cmp("big.mem_addr",   b_addr,           m_addr[0]);
      cmp("big.mem_wdata",  b_wdata,          m_data[0]);
      cmp("big.word_count", 32'(b_wc),        32'(m_cnt[0]));
      cmp("sml.in_ready",   32'(s_ready),     32'(m_act[1]));
      cmp("sml.cpu_reset",  32'(s_cpu_reset), 32'(!m_run[1]));
      cmp("sml.done",       32'(s_done),      32'(m_run[1]));
      cmp("sml.error",      32'(s_error),     32'(m_ovf[1]));
      cmp("sml.mem_we",     32'(s_we),        32'(m_we[1]));
      cmp("sml.mem_addr",   s_addr,           m_addr[1]);
      cmp("sml.mem_wdata",  s_wdata,          m_data[1]);
      cmp("sml.word_count", 32'(s_wc),        32'(m_cnt[1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic word(input logic [31:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  int we_seen;

  initial begin
    step(); step();
    cmp("rst.cpu_reset", 32'(b_cpu_reset), 32'd1);
    cmp("rst.in_ready",  32'(b_ready),     32'd0);
    cmp("rst.mem_addr",  s_addr,           S_BASE);
    cmp("rst.wc",        32'(b_wc),        32'd0);
    reset = 1'b0;

    // Three-word program, valid held high
    start = 1'b1; step(); start = 1'b0;
    word(32'h2008_0005, 1'b0); step();
    cmp("t1.we0",   32'(b_we), 32'd1);
    cmp("t1.addr0", b_addr,    32'h0);
    cmp("t1.data0", b_wdata,   32'h2008_0005);
    word(32'h2009_0007, 1'b0); step();
    cmp("t1.addr1", b_addr,    32'h4);
    word(32'h0109_5020, 1'b1); step();
    cmp("t1.addr2", b_addr,    32'h8);
    cmp("t1.data2", b_wdata,   32'h0109_5020);
    cmp("t1.cpurst_drain", 32'(b_cpu_reset), 32'd1);
    cmp("t1.ready_drain",  32'(b_ready),     32'd0);
    idle_in(); step();
    cmp("t1.cpurst_run", 32'(b_cpu_reset), 32'd0);
    cmp("t1.done",       32'(b_done),      32'd1);
    cmp("t1.wc",         32'(b_wc),        32'd3);
    cmp("t1.we_run",     32'(b_we),        32'd0);

    // Restart from RUN with a one-word image
    start = 1'b1; step(); start = 1'b0;
    cmp("t2.cpurst", 32'(b_cpu_reset), 32'd1);
    cmp("t2.done",   32'(b_done),      32'd0);
    cmp("t2.wc",     32'(b_wc),        32'd0);
    word(32'hCAFE_0001, 1'b1); step();
    cmp("t2.addr",   b_addr, 32'h0);
    idle_in(); step();
    cmp("t2.done1",  32'(b_done), 32'd1);
    cmp("t2.wc1",    32'(b_wc),   32'd1);

    // Bubbles interleaved with accepts
    start = 1'b1; step(); start = 1'b0;
    we_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) word(32'h1000 + i, 1'b1);
      else if (i % 2 == 0 && i < 4) word(32'h1000 + i, 1'b0);
      else idle_in();
      step();
      if (b_we) we_seen++;
    end
    cmp("t3.writes", 32'(we_seen), 32'd3);
    cmp("t3.wc",     32'(b_wc),    32'd3);

    // start during LOAD is ignored
    start = 1'b1; step(); start = 1'b0;
    word(32'h11, 1'b0); step();
    word(32'h22, 1'b0); step();
    start = 1'b1; word(32'h33, 1'b0); step(); start = 1'b0;
    cmp("t4.wc",    32'(b_wc),    32'd3);
    cmp("t4.ready", 32'(b_ready), 32'd1);
    word(32'h44, 1'b1); step();
    idle_in(); step();
    cmp("t4.done",  32'(s_done),  32'd1);
    cmp("t4.wc4",   32'(s_wc),    32'd4);

    // Overflow on the depth-4 instance
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      word(32'hA0 + i, 1'b0); step();
    end
    cmp("t5.we3",     32'(s_we),        32'd1);
    cmp("t5.addr3",   s_addr,           S_BASE + 32'hC);
    cmp("t5.error",   32'(s_error),     32'd1);
    cmp("t5.cpurst",  32'(s_cpu_reset), 32'd1);
    cmp("t5.wc",      32'(s_wc),        32'd4);
    cmp("t5.ready",   32'(s_ready),     32'd0);
    word(32'hA4, 1'b0); step();
    cmp("t5.we4",     32'(s_we),        32'd0);
    word(32'hA5, 1'b1); step();
    idle_in(); step();

    // Reset in the cycle of the second acceptance
    start = 1'b1; step(); start = 1'b0;
    word(32'hB0, 1'b0); step();
    word(32'hB1, 1'b0); reset = 1'b1; step(); reset = 1'b0; idle_in();
    cmp("t6.we",     32'(b_we),        32'd0);
    cmp("t6.ready",  32'(b_ready),     32'd0);
    cmp("t6.cpurst", 32'(b_cpu_reset), 32'd1);
    cmp("t6.addr",   b_addr,           32'h0);
    cmp("t6.wdata",  b_wdata,          32'h0);
    cmp("t6.wc",     32'(b_wc),        32'd0);
    step();

    // Random traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 29) == 0);
      in_valid = ($urandom_range(0, 9) < 6);
      in_last  = ($urandom_range(0, 9) == 0);
      in_data  = $urandom;
      step();
    end
    reset = 1'b0; start = 1'b0; idle_in();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning the word-address width; DEPTH = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0 in instruction memory.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a single-cycle load request.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, 32) and in_last (input, 1), forming the program-word stream; a word is accepted in a cycle where in_valid and in_ready are both 1.
REQ-007 SHALL have ports mem_we (output, 1), mem_addr (output, 32, byte address, word-aligned) and mem_wdata (output, 32), forming the instruction-memory write port.
REQ-008 SHALL have port cpu_reset, output, 1, holding the processor (PC, register file) in reset while 1.
REQ-009 SHALL have ports done (output, 1, load completed and CPU running) and error (output, 1, image overflow).
REQ-010 SHALL have port word_count, output, ADDR_WIDTH+1, the number of words accepted in the current load.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, DRAIN, RUN and ERROR.
REQ-012 IDLE: in_ready=0, cpu_reset=1; start -> LOAD with word_count cleared to 0.
REQ-013 LOAD: in_ready=1, cpu_reset=1; each accepted word is registered and written on the next cycle: mem_we=1, mem_addr=BASE_ADDR+4*index, mem_wdata=in_data (write latency 1 cycle).
REQ-014 LOAD acceptance with in_last=1 SHALL transition to DRAIN; in_ready SHALL be 0 from that next cycle.
REQ-015 LOAD acceptance with in_last=0 at index DEPTH-1 SHALL still write that word, then transition to ERROR.
REQ-016 DRAIN lasts exactly 1 cycle (final write issued), then transitions to RUN.
REQ-017 RUN: cpu_reset=0, done=1, in_ready=0; the first CPU fetch therefore occurs 2 cycles after the last-word acceptance.
REQ-018 ERROR: error=1, cpu_reset=1, in_ready=0, no writes.
REQ-019 start in RUN or ERROR SHALL re-enter LOAD: cpu_reset=1 and done/error cleared on the next cycle, word_count cleared to 0.
REQ-020 start in LOAD or DRAIN SHALL be ignored.
REQ-021 A cycle in LOAD with in_valid=0 SHALL be a bubble: no write, no state or count change.
REQ-022 mem_we SHALL be 0 in every cycle not following an acceptance.
REQ-023 word_count SHALL increment on acceptance, saturate at DEPTH, and hold in DRAIN, RUN and ERROR.

Reset
REQ-024 reset SHALL dominate start and stream inputs, forcing IDLE, cpu_reset=1, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, error=0 and word_count=0.
REQ-025 reset mid-LOAD SHALL abandon the load; the write pending from an acceptance in the reset cycle SHALL NOT be issued.

Structure
REQ-026 The state encodings and the default BASE_ADDR SHALL reside in the shared processor constants include, next to the opcode definitions.
REQ-027 SHALL be a single module; no sub-module is required (the counter and FSM are inline).

Verification
REQ-028 Load 3 words 0x20080005, 0x20090007, 0x01095020 (last on word 3) with in_valid held high -> writes at 0x0, 0x4 and 0x8 in consecutive cycles; cpu_reset falls 2 cycles after the third acceptance; done=1; word_count=3.
REQ-029 Stream with in_valid toggling 1,0,1,0,1(last) -> exactly 3 writes, each 1 cycle after its acceptance; no write in bubble cycles.
REQ-030 ADDR_WIDTH=2 with 5 words and no in_last -> 4 writes (the last at 0xC), error=1, cpu_reset stays 1, word_count=4, in_ready=0.
REQ-031 reset asserted in the cycle the second word is accepted -> no write of word 2; IDLE; all outputs at reset values on the next cycle.
REQ-032 start pulsed in RUN, then a 1-word load (last) -> cpu_reset=1 the cycle after start; the write goes to 0x0; RUN is re-entered with done=1 and word_count=1.
REQ-033 start pulsed during LOAD -> ignored; word_count continues counting from its current value.
